si_alien_fleet_shifter: RTL and testbench

SI_ALIEN_FLEET_SHIFTER -- requirements
Module: si_alien_fleet_shifter

---
 rtl/si_alien_fleet_shifter.sv | 128 ++++++++++++
 tb/tb_si_alien_fleet_shifter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/si_alien_fleet_shifter.sv
// Alien fleet row shifter: marches all rows sideways on divided frame ticks,
// bouncing off the playfield edges with a one-cycle descend step.
module si_alien_fleet_shifter #(
    parameter int unsigned FLEET_WIDTH = 8,
    parameter int unsigned FLEET_ROWS  = 4,
    parameter int unsigned STEP_DIV    = 16
) (
    input  logic                                        SC_ALIENFLEET_CLOCK_50,
    input  logic                                        SC_ALIENFLEET_RESET_InHigh,
    input  logic                                        SC_ALIENFLEET_clear_InLow,
    input  logic                                        SC_ALIENFLEET_load_InLow,
    input  logic [((FLEET_ROWS > 1) ? $clog2(FLEET_ROWS) : 1)-1:0] SC_ALIENFLEET_load_row_In,
    input  logic [FLEET_WIDTH-1:0]                      SC_ALIENFLEET_DataIn_InBus,
    input  logic                                        SC_ALIENFLEET_enable_In,
    input  logic                                        SC_ALIENFLEET_tick_In,
    input  logic                                        SC_ALIENFLEET_kill_InLow,
    input  logic [((FLEET_ROWS > 1) ? $clog2(FLEET_ROWS) : 1)-1:0] SC_ALIENFLEET_kill_row_In,
    input  logic [$clog2(FLEET_WIDTH)-1:0]              SC_ALIENFLEET_kill_col_In,
    output logic [FLEET_ROWS*FLEET_WIDTH-1:0]           SC_ALIENFLEET_data_OutBUS,
    output logic                                        SC_ALIENFLEET_dir_Out,
    output logic                                        SC_ALIENFLEET_descend_Out,
    output logic                                        SC_ALIENFLEET_empty_Out
);

    localparam int unsigned TW = FLEET_ROWS * FLEET_WIDTH;

    typedef enum logic [1:0] {IDLE, MARCH, DESCEND} state_t;

    state_t      state;
    logic [7:0]  tick_count;

    logic [TW-1:0] killed;
    logic [TW-1:0] shifted;
    logic [TW-1:0] next_fleet;
    logic          edge_r;
    logic          edge_l;
    logic          load_hit;
    logic          step;
    logic          go_descend;

    // Row update: kill is applied first, then edge detection and shifting
    // operate on the post-kill fleet.
    always_comb begin
        killed     = SC_ALIENFLEET_data_OutBUS;
        edge_r     = 1'b0;
        edge_l     = 1'b0;
        shifted    = '0;
        load_hit   = 1'b0;
        go_descend = 1'b0;

        for (int unsigned r = 0; r < FLEET_ROWS; r++) begin
            for (int unsigned c = 0; c < FLEET_WIDTH; c++) begin
                if (!SC_ALIENFLEET_kill_InLow && 32'(SC_ALIENFLEET_kill_row_In) == r
                    && 32'(SC_ALIENFLEET_kill_col_In) == c) begin
                    killed[r*FLEET_WIDTH + c] = 1'b0;
                end
            end
        end

        for (int unsigned r = 0; r < FLEET_ROWS; r++) begin
            edge_r = edge_r | killed[r*FLEET_WIDTH];
            edge_l = edge_l | killed[r*FLEET_WIDTH + FLEET_WIDTH - 1];
            if (SC_ALIENFLEET_dir_Out)
                shifted[r*FLEET_WIDTH +: FLEET_WIDTH] = killed[r*FLEET_WIDTH +: FLEET_WIDTH] << 1;
            else
                shifted[r*FLEET_WIDTH +: FLEET_WIDTH] = killed[r*FLEET_WIDTH +: FLEET_WIDTH] >> 1;
            if (!SC_ALIENFLEET_load_InLow && 32'(SC_ALIENFLEET_load_row_In) == r)
                load_hit = 1'b1;
        end

        step = (state == MARCH) && SC_ALIENFLEET_enable_In && SC_ALIENFLEET_tick_In
               && (32'(tick_count) + 32'd1 == STEP_DIV);

        next_fleet = killed;
        if (!SC_ALIENFLEET_clear_InLow) begin
            next_fleet = '0;
        end else if (load_hit) begin
            next_fleet = SC_ALIENFLEET_data_OutBUS;
            for (int unsigned r = 0; r < FLEET_ROWS; r++) begin
                if (32'(SC_ALIENFLEET_load_row_In) == r)
                    next_fleet[r*FLEET_WIDTH +: FLEET_WIDTH] = SC_ALIENFLEET_DataIn_InBus;
            end
        end else if (step && (|killed)) begin
            if (SC_ALIENFLEET_dir_Out ? edge_l : edge_r)
                go_descend = 1'b1;
            else
                next_fleet = shifted;
        end
    end

    // March FSM, tick divider and registered outputs.
    always_ff @(posedge SC_ALIENFLEET_CLOCK_50) begin
        if (SC_ALIENFLEET_RESET_InHigh) begin
            state                     <= IDLE;
            tick_count                <= 8'd0;
            SC_ALIENFLEET_data_OutBUS <= '0;
            SC_ALIENFLEET_dir_Out     <= 1'b0;
            SC_ALIENFLEET_descend_Out <= 1'b0;
            SC_ALIENFLEET_empty_Out   <= 1'b1;
        end else begin
            SC_ALIENFLEET_data_OutBUS <= next_fleet;
            SC_ALIENFLEET_empty_Out   <= ~(|next_fleet);
            SC_ALIENFLEET_descend_Out <= go_descend;
            case (state)
                IDLE: begin
                    if (SC_ALIENFLEET_enable_In)
                        state <= MARCH;
                end
                MARCH: begin
                    if (!SC_ALIENFLEET_enable_In) begin
                        state <= IDLE;
                    end else begin
                        if (SC_ALIENFLEET_tick_In)
                            tick_count <= step ? 8'd0 : tick_count + 8'd1;
                        if (go_descend)
                            state <= DESCEND;
                    end
                end
                DESCEND: begin
                    SC_ALIENFLEET_dir_Out <= ~SC_ALIENFLEET_dir_Out;
                    state                 <= MARCH;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_si_alien_fleet_shifter.sv
// Bench for si_alien_fleet_shifter: directed edge cases plus randomized
// traffic compared each cycle against a row-array reference model.
module tb_si_alien_fleet_shifter;

    localparam int unsigned W   = 8;
    localparam int unsigned R   = 3;
    localparam int unsigned DIV = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear_n;
    logic             load_n;
    logic [1:0]       load_row;
    logic [W-1:0]     data_in;
    logic             en;
    logic             tick;
    logic             kill_n;
    logic [1:0]       kill_row;
    logic [2:0]       kill_col;
    logic [R*W-1:0]   fleet;
    logic             dir;
    logic             desc;
    logic             empty;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: plain per-row integers and a few flags.
    int unsigned m_rows [R];
    int unsigned m_count;
    bit          m_dir;
    bit          m_desc;
    bit          m_march;

    si_alien_fleet_shifter #(.FLEET_WIDTH(W), .FLEET_ROWS(R), .STEP_DIV(DIV)) dut (
        .SC_ALIENFLEET_CLOCK_50     (clk),
        .SC_ALIENFLEET_RESET_InHigh (rst),
        .SC_ALIENFLEET_clear_InLow  (clear_n),
        .SC_ALIENFLEET_load_InLow   (load_n),
        .SC_ALIENFLEET_load_row_In  (load_row),
        .SC_ALIENFLEET_DataIn_InBus (data_in),
        .SC_ALIENFLEET_enable_In    (en),
        .SC_ALIENFLEET_tick_In      (tick),
        .SC_ALIENFLEET_kill_InLow   (kill_n),
        .SC_ALIENFLEET_kill_row_In  (kill_row),
        .SC_ALIENFLEET_kill_col_In  (kill_col),
        .SC_ALIENFLEET_data_OutBUS  (fleet),
        .SC_ALIENFLEET_dir_Out      (dir),
        .SC_ALIENFLEET_descend_Out  (desc),
        .SC_ALIENFLEET_empty_Out    (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        bit step_now;
        bit any;
        bit edge_hit;
        step_now = 1'b0;
        if (rst) begin
            foreach (m_rows[r]) m_rows[r] = 0;
            m_count = 0; m_dir = 0; m_desc = 0; m_march = 0;
            return;
        end
        if (m_desc) begin
            m_dir   = !m_dir;
            m_desc  = 0;
            m_march = 1;
        end else if (m_march) begin
            if (!en) m_march = 0;
            else if (tick) begin
                m_count++;
                if (m_count == DIV) begin
                    m_count  = 0;
                    step_now = 1;
                end
            end
        end else if (en) begin
            m_march = 1;
        end

        if (!clear_n) begin
            foreach (m_rows[r]) m_rows[r] = 0;
        end else if (!load_n && load_row < R) begin
            m_rows[load_row] = data_in;
        end else begin
            if (!kill_n && kill_row < R && kill_col < W)
                m_rows[kill_row] = m_rows[kill_row] & ~(32'd1 << kill_col);
            any = 0; edge_hit = 0;
            foreach (m_rows[r]) begin
                if (m_rows[r] != 0) any = 1;
                if (m_dir ? (m_rows[r] >= 128) : (m_rows[r] % 2 == 1)) edge_hit = 1;
            end
            if (step_now && any) begin
                if (edge_hit) m_desc = 1;
                else foreach (m_rows[r])
                    m_rows[r] = m_dir ? (m_rows[r] * 2) % 256 : m_rows[r] / 2;
            end
        end
    endtask

    function automatic logic [R*W-1:0] model_fleet();
        logic [R*W-1:0] v;
        v = '0;
        foreach (m_rows[r]) v[r*W +: W] = W'(m_rows[r]);
        return v;
    endfunction

    task automatic idle_inputs();
        rst = 0; clear_n = 1; load_n = 1; load_row = 0; data_in = 0;
        en = 0; tick = 0; kill_n = 1; kill_row = 0; kill_col = 0;
    endtask

    // One clock: model advances on the same inputs, outputs checked #1 later.
    task automatic cycle();
        bit all_zero;
        @(posedge clk);
        model_update();
        #1;
        all_zero = 1;
        foreach (m_rows[r]) if (m_rows[r] != 0) all_zero = 0;
        check("fleet", 64'(fleet), 64'(model_fleet()));
        check("dir",   64'(dir),   64'(m_dir));
        check("desc",  64'(desc),  64'(m_desc));
        check("empty", 64'(empty), 64'(all_zero));
        idle_inputs();
    endtask

    task automatic do_reset();
        rst = 1; cycle();
        rst = 1; cycle();
    endtask

    task automatic load0(input logic [W-1:0] v);
        load_n = 0; load_row = 0; data_in = v; cycle();
    endtask

    task automatic march(input int n_ticks);
        for (int i = 0; i < n_ticks; i++) begin
            en = 1; tick = 1; cycle();
        end
    endtask

    initial begin
        idle_inputs();
        do_reset();
        check("rst_fleet", 64'(fleet), 64'h0);
        check("rst_dir",   64'(dir),   64'h0);
        check("rst_desc",  64'(desc),  64'h0);
        check("rst_empty", 64'(empty), 64'h1);

        // Two steps to the right from 0x18.
        load0(8'h18);
        en = 1; cycle();
        march(4);
        check("march_row", 64'(fleet[7:0]), 64'h06);
        check("march_dir", 64'(dir), 64'h0);

        // Right edge bounce.
        do_reset();
        load0(8'h01);
        en = 1; cycle();
        march(2);
        check("bounce_desc", 64'(desc), 64'h1);
        check("bounce_row",  64'(fleet[7:0]), 64'h01);
        en = 1; cycle();
        check("bounce_desc_end", 64'(desc), 64'h0);
        check("bounce_dir", 64'(dir), 64'h1);
        march(2);
        check("bounce_left", 64'(fleet[7:0]), 64'h02);

        // Kill coincident with a right step.
        do_reset();
        load0(8'h0F);
        en = 1; cycle();
        march(1);
        en = 1; tick = 1; kill_n = 0; kill_row = 0; kill_col = 0; cycle();
        check("kill_shift", 64'(fleet[7:0]), 64'h07);

        // Load wins over a step and the divider restarts.
        do_reset();
        en = 1; cycle();
        march(1);
        en = 1; tick = 1; load_n = 0; load_row = 0; data_in = 8'hA0; cycle();
        check("load_step", 64'(fleet[7:0]), 64'hA0);
        march(1);
        check("load_cnt0", 64'(fleet[7:0]), 64'hA0);
        march(1);
        check("load_next", 64'(fleet[7:0]), 64'h50);

        // Killing everything empties the fleet; no descend afterwards.
        kill_n = 0; kill_row = 0; kill_col = 4; en = 1; cycle();
        kill_n = 0; kill_row = 0; kill_col = 6; en = 1; cycle();
        check("empty_after_kill", 64'(empty), 64'h1);
        for (int i = 0; i < 6; i++) begin
            en = 1; tick = 1; cycle();
            check("no_desc_empty", 64'(desc), 64'h0);
        end

        // Out-of-range load row and clear.
        load_n = 0; load_row = 2'd3; data_in = 8'hFF; cycle();
        check("bad_row_load", 64'(fleet), 64'h0);
        load_n = 0; load_row = 2'd2; data_in = 8'h3C; cycle();
        check("row2_load", 64'(fleet), 64'h3C0000);
        clear_n = 0; load_n = 0; load_row = 2'd1; data_in = 8'hFF; cycle();
        check("clear", 64'(fleet), 64'h0);

        // Reset during DESCEND drops the pending toggle.
        do_reset();
        load0(8'h01);
        en = 1; cycle();
        march(2);
        check("pre_rst_desc", 64'(desc), 64'h1);
        rst = 1; en = 1; cycle();
        check("rst_desc_fleet", 64'(fleet), 64'h0);
        check("rst_desc_dir",   64'(dir),   64'h0);
        check("rst_desc_desc",  64'(desc),  64'h0);
        check("rst_desc_empty", 64'(empty), 64'h1);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            clear_n  = ($urandom_range(0, 79) != 0);
            load_n   = ($urandom_range(0, 9) != 0);
            load_row = 2'($urandom_range(0, 3));
            data_in  = W'($urandom);
            en       = ($urandom_range(0, 9) != 0);
            tick     = ($urandom_range(0, 1) == 1);
            kill_n   = ($urandom_range(0, 4) != 0);
            kill_row = 2'($urandom_range(0, 3));
            kill_col = 3'($urandom_range(0, 7));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
